periph_regbank: RTL and testbench
=================================

# periph_regbank

Parametrised byte-addressed register bank that sits between the I2C slave controller's subaddress/write/read buses and a wide-operand compute core (Curve25519 first, other field-arithmetic cores later). It is the generalised successor of the fixed Curve25519 register set. Operand count and width are parameters, and the host reaches operand bytes through a pointer/data window with auto-increment. It sequences start/done with the core, snapshots results, flags protocol errors, and drives a maskable level interrupt.

## Interface
Parameters:
- OP_BYTES, 32: bytes per operand.
- NUM_IN, 2: input operand slots, host-writable.
- NUM_OUT, 1: output operand slots, core-written and host-readable.
- Constraint: (NUM_IN+NUM_OUT)*OP_BYTES <= 256. Elaboration fails otherwise.

Ports:
- clk  in  1  single clock; every flop is on its rising edge.
- reset  in  1  asynchronous reset, active-low.
- subaddr  in  8  register subaddress from the I2C slave.
- wr_data  in  8  write byte.
- wr_pulse  in  1  one-cycle write strobe.
- rd_data  out  8  read byte for the current subaddr.
- rd_pulse  in  1  one-cycle strobe: the host has consumed rd_data.
- core_op  out  NUM_IN*OP_BYTES*8  flattened input operands; byte 0 is the LSB.
- core_start  out  1  one-cycle start pulse to the core.
- core_res  in  NUM_OUT*OP_BYTES*8  flattened core result.
- core_done  in  1  one-cycle completion pulse from the core.
- done  out  1  level interrupt.

## Operation
Register map:
- 0x00 CTRL (RW).
  - bit0 START: write 1 to start; reads 0.
  - bit1 IRQ_EN.
  - bit2 AUTO_INC.
  - Reset value 0x04.
- 0x01 STATUS.
  - bit0 BUSY (RO).
  - bit1 DONE (W1C).
  - bit2 ERR (W1C).
- 0x02 PTR (RW): byte pointer into operand space.
- 0x03 DATA: the operand byte at PTR.
- Any other subaddr: reads 0x00, writes are ignored and do not set ERR.

Operand space:
- Bytes 0..NUM_IN*OP_BYTES-1 are the input operands.
- The next NUM_OUT*OP_BYTES bytes are the output operands.
- TOTAL = (NUM_IN+NUM_OUT)*OP_BYTES.

DATA access rules:
- A write to DATA at an input byte stores the byte.
- A write to DATA at an output byte is dropped and sets ERR.
- When AUTO_INC=1, every DATA write and every rd_pulse while subaddr==0x03 advance PTR by 1.
- PTR wraps from TOTAL-1 to 0.
- A PTR write of a value >= TOTAL stores 0 and sets ERR.

State machine:
- IDLE → RUN: START written. core_start pulses for one cycle, the cycle after the wr_pulse. BUSY=1.
- RUN → IDLE: on the core_done cycle. core_res is latched into the output bytes, DONE is set, BUSY clears.
- In RUN, these are ignored and set ERR: START writes, and DATA writes to input bytes. Inputs stay stable for the core.
- In IDLE, core_done is ignored.

Interrupt:
- done = DONE & IRQ_EN, registered.

Simultaneous events:
- A W1C of DONE in the same cycle that core_done sets it: set wins, DONE stays 1.
- The same rule applies to ERR.
- wr_pulse and rd_pulse together on DATA: the write is performed and PTR increments once.

Reset:
- Reset at any time, including mid-RUN, returns to IDLE.
- All registers and operand bytes clear to 0, except CTRL, which returns to 0x04.
- A later core_done from the aborted operation is ignored.

## Timing
- Write effect: visible in register state the cycle after wr_pulse.
- rd_data: registered. It reflects subaddr, PTR and register state from the previous cycle, so it has 1-cycle latency from a subaddr or PTR change.
- PTR increment: happens in the cycle after the rd_pulse. rd_data shows the next byte one further cycle later, which the I2C byte time easily covers.
- done: asserts 1 cycle after the DONE set.
- BUSY: reads 1 from the cycle after the START write until the cycle after core_done.
- Output reset values:
  - rd_data=0x00.
  - core_op=0.
  - core_start=0.
  - done=0.

## Structure
- Shared package holds:
  - the register subaddress constants (0x00–0x03);
  - the CTRL and STATUS bit indices;
  - the FSM state enum (IDLE, RUN).
- One natural sub-module: periph_ptr, the pointer register with load, increment, wrap and out-of-range detection, parametrised on TOTAL.
- Operand storage is a flat byte array in the parent.

## Test plan
- Reset, then read 0x00 and 0x01 → CTRL=0x04, STATUS=0x00, done=0.
- PTR=0x00, then 64 DATA writes of values 0..63 with AUTO_INC → core_op byte k equals k. PTR reads 0x40.
- START with IRQ_EN=1, then core_done 10 cycles later with core_res=0xA5 pattern → core_start is a single pulse; BUSY is 1 throughout; output bytes 64..95 read 0xA5; DONE=1; done rises; W1C of STATUS 0x02 drops done.
- Within RUN, a DATA write to byte 0 and a second START → byte 0 unchanged, ERR=1, no second core_start.
- PTR=95 (TOTAL=96), one DATA read with rd_pulse → PTR=0. Writing PTR=0x60 → PTR=0, ERR=1.
- Reset asserted mid-RUN, then core_done after release → state IDLE, DONE stays 0, output bytes stay 0.

Source files
------------

// File: rtl/periph_regbank_pkg.sv
// Shared definitions for the operand register bank: subaddresses, register bit
// positions and the core-sequencing state type.
package periph_regbank_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_PTR    = 8'h02;
  localparam logic [7:0] ADDR_DATA   = 8'h03;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_AUTO_INC = 2;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_ERR  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/periph_regbank_ptr.sv
// Operand-space byte pointer: load with range check, increment with wrap at TOTAL.
module periph_ptr #(
  parameter int unsigned TOTAL = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] ptr,
  output logic       load_err
);

  localparam logic [8:0] LIMIT = 9'(TOTAL);
  localparam logic [7:0] LAST  = 8'(TOTAL - 1);

  logic oob;

  assign oob      = {1'b0, load_val} >= LIMIT;
  assign load_err = load && oob;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= oob ? '0 : load_val;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 8'd1;
    end
  end

endmodule

// File: rtl/periph_regbank.sv
// Byte-addressed register bank fronting a wide-operand compute core: pointer/data
// window into operand space, start/done sequencing, error flag and level interrupt.
module periph_regbank
  import periph_regbank_pkg::*;
#(
  parameter int unsigned OP_BYTES = 32,
  parameter int unsigned NUM_IN   = 2,
  parameter int unsigned NUM_OUT  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    subaddr,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_pulse,
  output logic [7:0]                    rd_data,
  input  logic                          rd_pulse,
  output logic [NUM_IN*OP_BYTES*8-1:0]  core_op,
  output logic                          core_start,
  input  logic [NUM_OUT*OP_BYTES*8-1:0] core_res,
  input  logic                          core_done,
  output logic                          done
);

  localparam int unsigned IN_BYTES  = NUM_IN * OP_BYTES;
  localparam int unsigned OUT_BYTES = NUM_OUT * OP_BYTES;
  localparam int unsigned TOTAL     = IN_BYTES + OUT_BYTES;
  localparam int unsigned IDX_W     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [8:0]  IN_LIM    = 9'(IN_BYTES);

  if (TOTAL > 256 || TOTAL == 0) begin : g_bad_size
    $error("periph_regbank: operand space must hold 1..256 bytes");
  end

  state_t     state;
  logic       irq_en;
  logic       auto_inc;
  logic       done_flag;
  logic       err_flag;
  logic [7:0] ptr;
  logic       ptr_load_err;
  logic [7:0] mem [TOTAL];
  logic [7:0] rd_mux;

  logic wr_ctrl, wr_status, wr_ptr, wr_dat;
  logic running, start_req, in_range, data_store, ptr_inc, done_set, err_set;

  assign wr_ctrl    = wr_pulse && (subaddr == ADDR_CTRL);
  assign wr_status  = wr_pulse && (subaddr == ADDR_STATUS);
  assign wr_ptr     = wr_pulse && (subaddr == ADDR_PTR);
  assign wr_dat     = wr_pulse && (subaddr == ADDR_DATA);
  assign running    = (state == RUN);
  assign start_req  = wr_ctrl && wr_data[CTRL_START];
  assign in_range   = {1'b0, ptr} < IN_LIM;
  assign data_store = wr_dat && in_range && !running;
  assign done_set   = running && core_done;
  // A combined write+read strobe on DATA yields a single advance.
  assign ptr_inc    = auto_inc && (subaddr == ADDR_DATA) && (wr_pulse || rd_pulse);
  assign err_set    = (start_req && running)
                    || (wr_dat && (!in_range || running))
                    || ptr_load_err;

  periph_ptr #(
    .TOTAL(TOTAL)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (wr_ptr),
    .load_val (wr_data),
    .inc      (ptr_inc),
    .ptr      (ptr),
    .load_err (ptr_load_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      core_start <= 1'b0;
      irq_en     <= 1'b0;
      auto_inc   <= 1'b1;
      done_flag  <= 1'b0;
      err_flag   <= 1'b0;
      done       <= 1'b0;
      rd_data    <= '0;
    end else begin
      core_start <= 1'b0;
      if (wr_ctrl) begin
        irq_en   <= wr_data[CTRL_IRQ_EN];
        auto_inc <= wr_data[CTRL_AUTO_INC];
      end
      case (state)
        IDLE: if (start_req) begin
          state      <= RUN;
          core_start <= 1'b1;
        end
        RUN: if (core_done) state <= IDLE;
        default: state <= IDLE;
      endcase
      // Hardware set takes priority over a simultaneous write-1-to-clear.
      if (done_set) done_flag <= 1'b1;
      else if (wr_status && wr_data[ST_DONE]) done_flag <= 1'b0;
      if (err_set) err_flag <= 1'b1;
      else if (wr_status && wr_data[ST_ERR]) err_flag <= 1'b0;
      done    <= done_flag && irq_en;
      rd_data <= rd_mux;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < TOTAL; i++) mem[IDX_W'(i)] <= '0;
    end else begin
      if (data_store) mem[ptr[IDX_W-1:0]] <= wr_data;
      if (done_set) begin
        for (int unsigned i = 0; i < OUT_BYTES; i++)
          mem[IDX_W'(IN_BYTES + i)] <= core_res[i*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (subaddr)
      ADDR_CTRL: begin
        rd_mux[CTRL_IRQ_EN]   = irq_en;
        rd_mux[CTRL_AUTO_INC] = auto_inc;
      end
      ADDR_STATUS: begin
        rd_mux[ST_BUSY] = running;
        rd_mux[ST_DONE] = done_flag;
        rd_mux[ST_ERR]  = err_flag;
      end
      ADDR_PTR:  rd_mux = ptr;
      ADDR_DATA: rd_mux = mem[ptr[IDX_W-1:0]];
      default:   rd_mux = '0;
    endcase
  end

  always_comb begin
    core_op = '0;
    for (int unsigned i = 0; i < IN_BYTES; i++)
      core_op[i*8 +: 8] = mem[IDX_W'(i)];
  end

endmodule

// File: tb/tb_periph_regbank.sv
// Self-checking bench for periph_regbank: transaction-level model compared every
// cycle, plus directed literal expectations.
module tb_periph_regbank;

  localparam int unsigned OP_BYTES = 32;
  localparam int unsigned NUM_IN   = 2;
  localparam int unsigned NUM_OUT  = 1;
  localparam int unsigned IN_BYTES = NUM_IN * OP_BYTES;
  localparam int unsigned TOTAL    = (NUM_IN + NUM_OUT) * OP_BYTES;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   subaddr = 8'h00;
  logic [7:0]   wr_data = 8'h00;
  logic         wr_pulse = 1'b0;
  logic         rd_pulse = 1'b0;
  logic         core_done = 1'b0;
  logic [255:0] core_res = '0;
  logic [7:0]   rd_data;
  logic [511:0] core_op;
  logic         core_start;
  logic         done;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  periph_regbank #(
    .OP_BYTES(OP_BYTES),
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .subaddr    (subaddr),
    .wr_data    (wr_data),
    .wr_pulse   (wr_pulse),
    .rd_data    (rd_data),
    .rd_pulse   (rd_pulse),
    .core_op    (core_op),
    .core_start (core_start),
    .core_res   (core_res),
    .core_done  (core_done),
    .done       (done)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_op(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model of the register map and operand space.
  int unsigned m_ptr;
  bit          m_irq, m_ainc, m_busy, m_done, m_err, m_done_q, m_start_q;
  logic [7:0]  m_rd_q;
  logic [7:0]  m_bytes [TOTAL];
  logic [511:0] m_op;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return {5'd0, m_ainc, m_irq, 1'b0};
      8'h01:   return {5'd0, m_err, m_done, m_busy};
      8'h02:   return 8'(m_ptr);
      8'h03:   return m_bytes[7'(m_ptr)];
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit m_err_event();
    if (!wr_pulse) return 1'b0;
    case (subaddr)
      8'h00:   return wr_data[0] && m_busy;
      8'h02:   return 32'(wr_data) >= TOTAL;
      8'h03:   return (m_ptr >= IN_BYTES) || m_busy;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ptr <= 0; m_irq <= 1'b0; m_ainc <= 1'b1; m_busy <= 1'b0;
      m_done <= 1'b0; m_err <= 1'b0; m_done_q <= 1'b0; m_start_q <= 1'b0;
      m_rd_q <= 8'h00;
      for (int i = 0; i < TOTAL; i++) m_bytes[7'(i)] <= 8'h00;
    end else begin
      m_start_q <= 1'b0;
      m_done_q  <= m_done && m_irq;
      m_rd_q    <= m_read(subaddr);
      if (m_err_event()) m_err <= 1'b1;
      else if (wr_pulse && subaddr == 8'h01 && wr_data[2]) m_err <= 1'b0;
      if (m_busy && core_done) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
        for (int k = 0; k < TOTAL - IN_BYTES; k++)
          m_bytes[7'(IN_BYTES + k)] <= core_res[8*k +: 8];
      end else if (wr_pulse && subaddr == 8'h01 && wr_data[1]) begin
        m_done <= 1'b0;
      end
      if (wr_pulse && subaddr == 8'h00) begin
        m_irq  <= wr_data[1];
        m_ainc <= wr_data[2];
        if (wr_data[0] && !m_busy) begin
          m_busy    <= 1'b1;
          m_start_q <= 1'b1;
        end
      end
      if (wr_pulse && subaddr == 8'h03 && m_ptr < IN_BYTES && !m_busy)
        m_bytes[7'(m_ptr)] <= wr_data;
      if (wr_pulse && subaddr == 8'h02)
        m_ptr <= (32'(wr_data) >= TOTAL) ? 0 : 32'(wr_data);
      else if (m_ainc && subaddr == 8'h03 && (wr_pulse || rd_pulse))
        m_ptr <= (m_ptr + 1) % TOTAL;
    end
  end

  always_comb begin
    m_op = '0;
    for (int i = 0; i < IN_BYTES; i++) m_op[8*i +: 8] = m_bytes[7'(i)];
  end

  always @(negedge clk) begin
    if (reset) begin
      chk8("cyc_rd_data", rd_data, m_rd_q);
      chk8("cyc_core_start", 8'(core_start), 8'(m_start_q));
      chk8("cyc_done", 8'(done), 8'(m_done_q));
      chk_op("cyc_core_op", core_op, m_op);
    end
  end

  always @(negedge clk) if (reset && core_start) start_cnt <= start_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    subaddr = a; wr_data = d; wr_pulse = 1'b1;
    @(negedge clk);
    wr_pulse = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [7:0] v);
    subaddr = a;
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic data_rd(output logic [7:0] v);
    subaddr = 8'h03;
    @(negedge clk);
    v = rd_data;
    rd_pulse = 1'b1;
    @(negedge clk);
    rd_pulse = 1'b0;
  endtask

  initial begin
    logic [7:0]   v;
    logic [511:0] exp_op;

    #1 reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);

    reg_rd(8'h00, v); chk8("reset_ctrl", v, 8'h04);
    reg_rd(8'h01, v); chk8("reset_status", v, 8'h00);
    chk8("reset_done", 8'(done), 8'h00);
    chk_op("reset_core_op", core_op, '0);

    reg_wr(8'h02, 8'h00);
    for (int k = 0; k < 64; k++) reg_wr(8'h03, 8'(k));
    exp_op = '0;
    for (int k = 0; k < 64; k++) exp_op[8*k +: 8] = 8'(k);
    chk_op("fill_core_op", core_op, exp_op);
    reg_rd(8'h02, v); chk8("ptr_after_fill", v, 8'h40);

    reg_wr(8'h02, 8'd10);
    subaddr = 8'h03; wr_data = 8'h77; wr_pulse = 1'b1; rd_pulse = 1'b1;
    @(negedge clk);
    wr_pulse = 1'b0; rd_pulse = 1'b0;
    reg_rd(8'h02, v); chk8("wr_rd_same_ptr", v, 8'd11);
    chk8("wr_rd_same_byte", core_op[87:80], 8'h77);

    reg_wr(8'h00, 8'h07);
    chk8("start_pulse_hi", 8'(core_start), 8'h01);
    tick(1);
    chk8("start_pulse_lo", 8'(core_start), 8'h00);
    reg_rd(8'h01, v); chk8("busy_run", v, 8'h01);
    reg_wr(8'h02, 8'h00);
    reg_wr(8'h03, 8'hFF);
    reg_wr(8'h00, 8'h07);
    reg_rd(8'h01, v); chk8("run_err_status", v, 8'h05);
    chk8("run_byte0_kept", core_op[7:0], 8'h00);
    tick(3);
    core_res = {32{8'hA5}}; core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    reg_rd(8'h01, v); chk8("done_status", v, 8'h06);
    chk8("done_irq_high", 8'(done), 8'h01);
    chk8("single_start", 8'(start_cnt), 8'h01);
    reg_wr(8'h01, 8'h02);
    tick(1);
    chk8("done_irq_cleared", 8'(done), 8'h00);
    reg_rd(8'h01, v); chk8("err_still_set", v, 8'h04);
    reg_wr(8'h01, 8'h04);
    reg_rd(8'h01, v); chk8("status_cleared", v, 8'h00);

    reg_wr(8'h02, 8'd64);
    for (int k = 0; k < 32; k++) begin
      data_rd(v); chk8("out_byte", v, 8'hA5);
    end
    reg_rd(8'h02, v); chk8("ptr_wrap_sweep", v, 8'h00);
    reg_wr(8'h02, 8'd95);
    data_rd(v); chk8("last_byte", v, 8'hA5);
    reg_rd(8'h02, v); chk8("ptr_wrap_95", v, 8'h00);
    reg_wr(8'h02, 8'h60);
    reg_rd(8'h02, v); chk8("ptr_oob_zero", v, 8'h00);
    reg_rd(8'h01, v); chk8("ptr_oob_err", v, 8'h04);
    reg_wr(8'h01, 8'h04);

    reg_wr(8'h00, 8'h07);
    tick(2);
    core_done = 1'b1; subaddr = 8'h01; wr_data = 8'h02; wr_pulse = 1'b1;
    @(negedge clk);
    core_done = 1'b0; wr_pulse = 1'b0;
    reg_rd(8'h01, v); chk8("done_set_wins", v, 8'h02);
    reg_wr(8'h01, 8'h02);

    reg_wr(8'h00, 8'h07);
    tick(3);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    core_res = {32{8'h5A}}; core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    tick(1);
    reg_rd(8'h01, v); chk8("abort_status", v, 8'h00);
    reg_rd(8'h00, v); chk8("abort_ctrl", v, 8'h04);
    chk8("abort_done", 8'(done), 8'h00);
    reg_wr(8'h02, 8'd64);
    data_rd(v); chk8("abort_out_first", v, 8'h00);
    reg_wr(8'h02, 8'd95);
    data_rd(v); chk8("abort_out_last", v, 8'h00);
    chk_op("abort_core_op", core_op, '0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
